// File: rtl/mc_controller.sv
// mc_controller: multicycle RV32I control FSM with ALU and immediate decoders
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       Illegal,
  output logic [3:0] State
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;
  state_t     state, next;
  logic       pc_update, branch, mem_write, ir_write, reg_write;
  logic [1:0] alu_op;
  // State register; asynchronous clear to FETCH
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= FETCH;
    else state <= next;
  // Next-state and per-state Moore outputs; unused codes fall back to FETCH with defaults
  always_comb begin
    next      = FETCH;
    pc_update = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = 2'b00;
    Illegal   = 1'b0;
    case (state)
      FETCH: begin
        ir_write  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
        next      = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: next = MEMADR;
          7'b0110011: next = EXECR;
          7'b0010011: next = EXECI;
          7'b1100011: next = BEQ;
          7'b1101111: next = JAL;
          default: Illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        next    = op == 7'b0000011 ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        next   = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
        next    = ALUWB;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        next    = ALUWB;
      end
      ALUWB: reg_write = 1'b1;
      BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        next      = ALUWB;
      end
      default: next = FETCH;
    endcase
  end
  // ALU decoder: subtract only for R-type funct3=000 with funct7b5 set
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10:
        case (funct3)
          3'b000: ALUControl = {op[5], funct7b5} == 2'b11 ? 3'b001 : 3'b000;
          3'b010: ALUControl = 3'b101;
          3'b110: ALUControl = 3'b011;
          3'b111: ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      default: ALUControl = 3'b000;
    endcase
  end
  // Immediate format from opcode, independent of state
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      7'b0100011: ImmSrc = 2'b01;
      7'b1100011: ImmSrc = 2'b10;
      7'b1101111: ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end
  assign PCWrite  = reset & (pc_update | (branch & Zero));
  assign IRWrite  = reset & ir_write;
  assign MemWrite = reset & mem_write;
  assign RegWrite = reset & reg_write;
  assign State    = state;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized instruction-level check of mc_controller against a behavioural model
module tb_mc_controller;
  logic       clk, reset, funct7b5, Zero;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;
  int         checks = 0;
  int         errors = 0;
  typedef int path_t[$];
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .Illegal(Illegal), .State(State)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  // Global time bound
  initial begin
    #500000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic bit legal(input logic [6:0] o);
    return o == LW || o == SW || o == RT || o == IT || o == BQ || o == JL;
  endfunction
  // Sequence of states an instruction walks through, starting at FETCH
  function automatic path_t path(input logic [6:0] o);
    case (o)
      LW: return '{0, 1, 2, 3, 4};
      SW: return '{0, 1, 2, 5};
      RT: return '{0, 1, 6, 8};
      IT: return '{0, 1, 7, 8};
      BQ: return '{0, 1, 9};
      JL: return '{0, 1, 10, 8};
      default: return '{0, 1};
    endcase
  endfunction
  // {AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB} by state
  function automatic logic [9:0] exp_ctl(input int s);
    case (s)
      0: return 10'b0010_10_00_10;
      1: return 10'b0000_00_01_01;
      2: return 10'b0000_00_10_01;
      3: return 10'b1000_00_00_00;
      4: return 10'b0001_01_00_00;
      5: return 10'b1100_00_00_00;
      6: return 10'b0000_00_10_00;
      7: return 10'b0000_00_10_01;
      8: return 10'b0001_00_00_00;
      9: return 10'b0000_00_10_00;
      10: return 10'b0000_00_01_10;
      default: return 10'b0;
    endcase
  endfunction
  // ALU operation from instruction meaning: beq compares by subtraction, sub only for R-type
  function automatic logic [2:0] exp_alu(input int s, input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (s == 9) return 3'd1;
    if (s != 6 && s != 7) return 3'd0;
    case (f3)
      3'd0: return (o == RT && f7) ? 3'd1 : 3'd0;
      3'd2: return 3'd5;
      3'd6: return 3'd3;
      3'd7: return 3'd2;
      default: return 3'd0;
    endcase
  endfunction
  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    return o == SW ? 2'd1 : o == BQ ? 2'd2 : o == JL ? 2'd3 : 2'd0;
  endfunction
  task automatic check_cycle(input int s);
    logic [9:0] c;
    c = exp_ctl(s);
    check($sformatf("s%0d_state", s), State, s);
    check($sformatf("s%0d_adrsrc", s), AdrSrc, c[9]);
    check($sformatf("s%0d_memwrite", s), MemWrite, c[8]);
    check($sformatf("s%0d_irwrite", s), IRWrite, c[7]);
    check($sformatf("s%0d_regwrite", s), RegWrite, c[6]);
    check($sformatf("s%0d_resultsrc", s), ResultSrc, c[5:4]);
    check($sformatf("s%0d_alusrca", s), ALUSrcA, c[3:2]);
    check($sformatf("s%0d_alusrcb", s), ALUSrcB, c[1:0]);
    check($sformatf("s%0d_pcwrite", s), PCWrite, (s == 0 || s == 10 || (s == 9 && Zero)));
    check($sformatf("s%0d_alucontrol", s), ALUControl, exp_alu(s, op, funct3, funct7b5));
    check($sformatf("s%0d_immsrc", s), ImmSrc, exp_imm(op));
    check($sformatf("s%0d_illegal", s), Illegal, (s == 1 && !legal(op)));
  endtask
  // Runs one whole instruction; zmode 0/1 fixes Zero, 2 randomizes it per cycle
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input int zmode);
    path_t q;
    q = path(o);
    op = o;
    funct3 = f3;
    funct7b5 = f7;
    foreach (q[i]) begin
      Zero = zmode == 2 ? 1'($urandom % 2) : 1'(zmode);
      @(negedge clk);
      check_cycle(q[i]);
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    logic [6:0] o;
    logic [6:0] ops [6];
    ops = '{LW, SW, RT, IT, BQ, JL};
    reset = 0;
    op = LW;
    funct3 = 0;
    funct7b5 = 0;
    Zero = 0;
    repeat (3) begin
      @(negedge clk);
      check("rst_state", State, 0);
      check("rst_pcwrite", PCWrite, 0);
      check("rst_irwrite", IRWrite, 0);
      check("rst_memwrite", MemWrite, 0);
      check("rst_regwrite", RegWrite, 0);
    end
    @(posedge clk);
    #1 reset = 1;
    run_instr(LW, 3'd2, 0, 0);
    run_instr(SW, 3'd2, 0, 0);
    run_instr(RT, 3'd0, 1, 0);
    run_instr(RT, 3'd6, 0, 0);
    run_instr(RT, 3'd2, 0, 0);
    run_instr(RT, 3'd7, 0, 0);
    run_instr(IT, 3'd0, 1, 0);
    run_instr(BQ, 3'd0, 0, 1);
    run_instr(BQ, 3'd0, 0, 0);
    run_instr(JL, 3'd0, 0, 0);
    run_instr(7'b1111111, 3'd0, 0, 0);
    op = SW;
    Zero = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_cycle(i == 0 ? 0 : i == 1 ? 1 : 2);
      @(posedge clk);
      #1;
    end
    #1;
    check("mid_state_before", State, 5);
    check("mid_memwrite_before", MemWrite, 1);
    reset = 0;
    #1;
    check("mid_state_after", State, 0);
    check("mid_memwrite_after", MemWrite, 0);
    @(posedge clk);
    #1 reset = 1;
    for (int n = 0; n < 250; n++) begin
      if ($urandom % 8 == 0) begin
        do o = 7'($urandom); while (legal(o));
      end else o = ops[$urandom % 6];
      run_instr(o, 3'($urandom), 1'($urandom), 2);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
